// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
//
// Memory-stage access controller for the pipelined LC-3b datapath. It sits
// directly downstream of the EX/MEM register, takes the decoded control fields
// of the instruction held there and runs the matching data-cache transaction
// over a read/write/resp handshake:
//   - one access for LDR/LDB/STR/STB,
//   - two accesses for LDI/STI (fetch the pointer word, then the final access
//     at that pointer).
// Byte-lane alignment is done here. The upstream pipeline is stalled until the
// final access completes.
//
// Optional feature (compile-time macro DCACHE_TIMEOUT_EN):
//   When defined, a wait counter aborts an access after TIMEOUT_CYCLES cycles
//   without dmem_resp and sets the sticky mem_error flag. When undefined, there
//   is no counter, mem_error is tied low and the controller waits indefinitely.
//
// Parameters
//   TIMEOUT_CYCLES    cycles waited for dmem_resp before an abort (timeout build only)
//
// Ports
//   clk               clock, rising edge
//   reset_n           asynchronous active-low reset
//   valid_in          EX/MEM holds a live instruction
//   opcode[3:0]       LC-3b opcode of that instruction
//   dcache_enable     instruction uses the data cache
//   dcacheR/dcacheW   final access is a read / a write
//   address[15:0]     effective address from EX
//   store_data[15:0]  source register value for STR/STB/STI
//   dmem_resp         cache completes the current access this cycle
//   dmem_rdata[15:0]  cache read data, valid with dmem_resp
//   dmem_read         read request, held until resp (registered)
//   dmem_write        write request, held until resp (registered)
//   dmem_address      access address (registered)
//   dmem_wdata        write data (registered)
//   dmem_byte_enable  write mask, bit1 = high byte (registered)
//   mem_rdata[15:0]   load result to WB, held until the next load completes
//   stall             combinational, freezes all upstream pipeline registers
//   mem_error         sticky timeout flag
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_in,
    input  logic [3:0]  opcode,
    input  logic        dcache_enable,
    input  logic        dcacheR,
    input  logic        dcacheW,
    input  logic [15:0] address,
    input  logic [15:0] store_data,
    input  logic        dmem_resp,
    input  logic [15:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    output logic [15:0] mem_rdata,
    output logic        stall,
    output logic        mem_error
);

    localparam logic [3:0] OP_LDB = 4'd2;
    localparam logic [3:0] OP_STB = 4'd3;
    localparam logic [3:0] OP_LDI = 4'd10;
    localparam logic [3:0] OP_STI = 4'd11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        INDIRECT = 2'd2
    } state_t;

    state_t state, state_next;

    // Instruction fields captured on acceptance; the EX/MEM register may move
    // on as soon as stall drops, so the final phase must not rely on inputs.
    logic [3:0]  op_q;
    logic        addr_lsb_q;
    logic [15:0] sdata_q;
    logic        rd_q;
    logic        wr_q;

    logic        read_next;
    logic        write_next;
    logic [15:0] addr_next;
    logic [15:0] wdata_next;
    logic [1:0]  be_next;
    logic        load_en;

    logic        accept;
    logic        busy;
    logic        is_ind_in;
    logic        is_ind_q;
    logic        final_phase;
    logic        final_resp;
    logic        timeout_hit;

    // Word-align an address by clearing bit 0.
    function automatic logic [15:0] align_word(input logic [14:0] upper);
        return {upper, 1'b0};
    endfunction

    // LDB returns the addressed byte zero-extended; all other loads the word.
    function automatic logic [15:0] load_format(input logic [3:0]  op,
                                                input logic        hi_byte,
                                                input logic [15:0] rdata);
        if (op == OP_LDB)
            return {8'h00, (hi_byte ? rdata[15:8] : rdata[7:0])};
        return rdata;
    endfunction

    // STB replicates the byte on both lanes; the byte enable picks the lane.
    function automatic logic [15:0] stb_lanes(input logic [7:0] b);
        return {b, b};
    endfunction

    assign accept      = (state == IDLE) && valid_in && dcache_enable && (dcacheR || dcacheW);
    assign busy        = (state == ACCESS) || (state == INDIRECT);
    assign is_ind_in   = (opcode == OP_LDI) || (opcode == OP_STI);
    assign is_ind_q    = (op_q == OP_LDI) || (op_q == OP_STI);
    assign final_phase = (state == INDIRECT) || ((state == ACCESS) && !is_ind_q);
    assign final_resp  = final_phase && dmem_resp;

    // The abort cycle itself releases the pipeline.
    assign stall = accept || (busy && !final_resp && !timeout_hit);

`ifdef DCACHE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Fires in the cycle that would be the TIMEOUT_CYCLES-th wait cycle.
    assign timeout_hit = busy && !dmem_resp && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            if (!busy || dmem_resp || timeout_hit)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;
            if (timeout_hit)
                mem_error <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign mem_error   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state and next values of the registered cache interface
    always_comb begin
        state_next = state;
        read_next  = dmem_read;
        write_next = dmem_write;
        addr_next  = dmem_address;
        wdata_next = dmem_wdata;
        be_next    = dmem_byte_enable;
        load_en    = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ACCESS;
                    if (is_ind_in) begin
                        // Pointer fetch is always a full-word read.
                        read_next  = 1'b1;
                        write_next = 1'b0;
                        addr_next  = align_word(address[15:1]);
                        wdata_next = 16'h0000;
                        be_next    = 2'b11;
                    end else if (dcacheR) begin
                        read_next  = 1'b1;
                        write_next = 1'b0;
                        addr_next  = align_word(address[15:1]);
                        wdata_next = 16'h0000;
                        be_next    = 2'b11;
                    end else if (opcode == OP_STB) begin
                        // Byte store keeps the unaligned address.
                        read_next  = 1'b0;
                        write_next = 1'b1;
                        addr_next  = address;
                        wdata_next = stb_lanes(store_data[7:0]);
                        be_next    = address[0] ? 2'b10 : 2'b01;
                    end else begin
                        read_next  = 1'b0;
                        write_next = 1'b1;
                        addr_next  = align_word(address[15:1]);
                        wdata_next = store_data;
                        be_next    = 2'b11;
                    end
                end
            end

            ACCESS: begin
                if (timeout_hit) begin
                    state_next = IDLE;
                    read_next  = 1'b0;
                    write_next = 1'b0;
                    addr_next  = 16'h0000;
                    wdata_next = 16'h0000;
                    be_next    = 2'b00;
                end else if (dmem_resp) begin
                    if (is_ind_q) begin
                        // Pointer arrived: switch straight to the final access.
                        state_next = INDIRECT;
                        read_next  = rd_q;
                        write_next = !rd_q && wr_q;
                        addr_next  = align_word(dmem_rdata[15:1]);
                        wdata_next = rd_q ? 16'h0000 : sdata_q;
                        be_next    = 2'b11;
                    end else begin
                        state_next = IDLE;
                        read_next  = 1'b0;
                        write_next = 1'b0;
                        addr_next  = 16'h0000;
                        wdata_next = 16'h0000;
                        be_next    = 2'b00;
                        load_en    = rd_q;
                    end
                end
            end

            INDIRECT: begin
                if (timeout_hit || dmem_resp) begin
                    state_next = IDLE;
                    read_next  = 1'b0;
                    write_next = 1'b0;
                    addr_next  = 16'h0000;
                    wdata_next = 16'h0000;
                    be_next    = 2'b00;
                    load_en    = dmem_resp && rd_q;
                end
            end

            default: begin
                state_next = IDLE;
                read_next  = 1'b0;
                write_next = 1'b0;
                addr_next  = 16'h0000;
                wdata_next = 16'h0000;
                be_next    = 2'b00;
            end
        endcase
    end

    // Registered cache interface, captured instruction fields and load result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_address     <= 16'h0000;
            dmem_wdata       <= 16'h0000;
            dmem_byte_enable <= 2'b00;
            mem_rdata        <= 16'h0000;
            op_q             <= 4'h0;
            addr_lsb_q       <= 1'b0;
            sdata_q          <= 16'h0000;
            rd_q             <= 1'b0;
            wr_q             <= 1'b0;
        end else begin
            dmem_read        <= read_next;
            dmem_write       <= write_next;
            dmem_address     <= addr_next;
            dmem_wdata       <= wdata_next;
            dmem_byte_enable <= be_next;
            if (accept) begin
                op_q       <= opcode;
                addr_lsb_q <= address[0];
                sdata_q    <= store_data;
                rd_q       <= dcacheR;
                wr_q       <= dcacheW;
            end
            if (load_en)
                mem_rdata <= load_format(op_q, addr_lsb_q, dmem_rdata);
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    logic        clk;
    logic        reset_n;
    logic        valid_in;
    logic [3:0]  opcode;
    logic        dcache_enable;
    logic        dcacheR;
    logic        dcacheW;
    logic [15:0] address;
    logic [15:0] store_data;
    logic        dmem_resp;
    logic [15:0] dmem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] mem_rdata;
    logic        stall;
    logic        mem_error;

    int checks = 0;
    int errors = 0;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .valid_in         (valid_in),
        .opcode           (opcode),
        .dcache_enable    (dcache_enable),
        .dcacheR          (dcacheR),
        .dcacheW          (dcacheW),
        .address          (address),
        .store_data       (store_data),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .mem_rdata        (mem_rdata),
        .stall            (stall),
        .mem_error        (mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic        en;
        logic        r;
        logic        w;
        logic [15:0] addr;
        logic [15:0] sdata;
        logic [15:0] rdata;
        logic        exp_stall;
        logic        exp_rd;
        logic        exp_wr;
        logic [15:0] exp_addr;
        logic [15:0] exp_wdata;
        logic [1:0]  exp_be;
        logic [15:0] exp_mem;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic en,
                         input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] sd);
        valid_in      = v;
        opcode        = op;
        dcache_enable = en;
        dcacheR       = r;
        dcacheW       = w;
        address       = a;
        store_data    = sd;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", i);
        // Cycle A: instruction presented in IDLE
        next_cycle();
        drive(v.valid, v.op, v.en, v.r, v.w, v.addr, v.sdata);
        dmem_resp  = 1'b0;
        dmem_rdata = 16'h0000;
        #1;
        check({tag, " stall"}, {15'd0, stall}, {15'd0, v.exp_stall});
        if (v.exp_stall) begin
            // Cycle B: request visible, zero-wait completion
            next_cycle();
            dmem_resp  = 1'b1;
            dmem_rdata = v.rdata;
            #1;
            check({tag, " read"},  {15'd0, dmem_read},  {15'd0, v.exp_rd});
            check({tag, " write"}, {15'd0, dmem_write}, {15'd0, v.exp_wr});
            check({tag, " addr"},  dmem_address, v.exp_addr);
            check({tag, " wdata"}, dmem_wdata, v.exp_wdata);
            check({tag, " be"},    {14'd0, dmem_byte_enable}, {14'd0, v.exp_be});
            check({tag, " stall_done"}, {15'd0, stall}, 16'd0);
        end
        // Final cycle: request released, load result in place
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        dmem_resp = 1'b0;
        #1;
        check({tag, " req_off"}, {14'd0, dmem_read, dmem_write}, 16'd0);
        check({tag, " mem_rdata"}, mem_rdata, v.exp_mem);
    endtask

    initial begin
        int stall_cycles;

        //              valid op     en    r     w     addr      sdata     rdata     stl   rd    wr    eaddr     ewdata    ebe    emem
        vecs[0] = '{1'b1, 4'd6,  1'b1, 1'b1, 1'b0, 16'h3001, 16'h0000, 16'hABCD, 1'b1, 1'b1, 1'b0, 16'h3000, 16'h0000, 2'b11, 16'hABCD};
        vecs[1] = '{1'b1, 4'd3,  1'b1, 1'b0, 1'b1, 16'h2000, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h2000, 16'h3434, 2'b01, 16'hABCD};
        vecs[2] = '{1'b1, 4'd3,  1'b1, 1'b0, 1'b1, 16'h2001, 16'h12FE, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h2001, 16'hFEFE, 2'b10, 16'hABCD};
        vecs[3] = '{1'b1, 4'd7,  1'b1, 1'b0, 1'b1, 16'h2003, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h2002, 16'h1234, 2'b11, 16'hABCD};
        vecs[4] = '{1'b1, 4'd2,  1'b1, 1'b1, 1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h3000, 16'h0000, 2'b11, 16'h0034};
        vecs[5] = '{1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 16'h0034};
        vecs[6] = '{1'b1, 4'd6,  1'b1, 1'b0, 1'b0, 16'h5555, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 16'h0034};
        vecs[7] = '{1'b0, 4'd6,  1'b1, 1'b1, 1'b0, 16'h7777, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 16'h0034};
        vecs[8] = '{1'b1, 4'd2,  1'b1, 1'b1, 1'b0, 16'h3001, 16'h0000, 16'hABCD, 1'b1, 1'b1, 1'b0, 16'h3000, 16'h0000, 2'b11, 16'h00AB};

        reset_n = 1'b1;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        dmem_resp  = 1'b0;
        dmem_rdata = 16'h0000;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst read",  {15'd0, dmem_read}, 16'd0);
        check("rst write", {15'd0, dmem_write}, 16'd0);
        check("rst addr",  dmem_address, 16'h0000);
        check("rst wdata", dmem_wdata, 16'h0000);
        check("rst be",    {14'd0, dmem_byte_enable}, 16'd0);
        check("rst mem",   mem_rdata, 16'h0000);
        check("rst stall", {15'd0, stall}, 16'd0);
        check("rst err",   {15'd0, mem_error}, 16'd0);
        #3 reset_n = 1'b1;

        // Table of single-access and non-access instructions
        for (int i = 0; i < 9; i++)
            run_vec(i, vecs[i]);

        // LDB 0x3001 with two cache wait cycles
        stall_cycles = 0;
        next_cycle();
        drive(1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 16'h3001, 16'h0000);
        #1;
        if (stall) stall_cycles++;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            dmem_resp  = (c == 2);
            dmem_rdata = (c == 2) ? 16'hABCD : 16'h0000;
            #1;
            check("ldb_wait read", {15'd0, dmem_read}, 16'd1);
            if (stall) stall_cycles++;
        end
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        dmem_resp = 1'b0;
        #1;
        check("ldb_wait stalls", 16'(stall_cycles), 16'd3);
        check("ldb_wait mem", mem_rdata, 16'h00AB);
        check("ldb_wait read_off", {15'd0, dmem_read}, 16'd0);

        // LDI 0x4000 -> pointer 0x5002 -> 0xBEEF, zero-wait cache
        next_cycle();
        drive(1'b1, 4'd10, 1'b1, 1'b1, 1'b0, 16'h4000, 16'h0000);
        #1;
        check("ldi stall0", {15'd0, stall}, 16'd1);
        next_cycle();
        dmem_resp  = 1'b1;
        dmem_rdata = 16'h5002;
        #1;
        check("ldi ptr read", {15'd0, dmem_read}, 16'd1);
        check("ldi ptr addr", dmem_address, 16'h4000);
        check("ldi stall1", {15'd0, stall}, 16'd1);
        next_cycle();
        dmem_rdata = 16'hBEEF;
        #1;
        check("ldi fin read", {15'd0, dmem_read}, 16'd1);
        check("ldi fin addr", dmem_address, 16'h5002);
        check("ldi stall2", {15'd0, stall}, 16'd0);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        dmem_resp = 1'b0;
        #1;
        check("ldi mem", mem_rdata, 16'hBEEF);
        check("ldi read_off", {15'd0, dmem_read}, 16'd0);

        // Stray resp while idle must be ignored
        next_cycle();
        dmem_resp  = 1'b1;
        dmem_rdata = 16'h1111;
        #1;
        check("stray stall", {15'd0, stall}, 16'd0);
        next_cycle();
        dmem_resp = 1'b0;
        #1;
        check("stray mem", mem_rdata, 16'hBEEF);
        check("stray req", {14'd0, dmem_read, dmem_write}, 16'd0);

        // STR 0x0103 with three wait cycles
        next_cycle();
        drive(1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 16'h0103, 16'hA5A5);
        #1;
        check("str_wait stall0", {15'd0, stall}, 16'd1);
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            dmem_resp = (c == 3);
            #1;
            check("str_wait write", {15'd0, dmem_write}, 16'd1);
            check("str_wait addr", dmem_address, 16'h0102);
            check("str_wait stall", {15'd0, stall}, (c == 3) ? 16'd0 : 16'd1);
            check("str_wait err", {15'd0, mem_error}, 16'd0);
        end
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        dmem_resp = 1'b0;
        #1;
        check("str_wait write_off", {15'd0, dmem_write}, 16'd0);
        check("str_wait mem", mem_rdata, 16'hBEEF);

        // STI reset while the final write is pending
        next_cycle();
        drive(1'b1, 4'd11, 1'b1, 1'b0, 1'b1, 16'h4000, 16'h5555);
        #1;
        next_cycle();
        dmem_resp  = 1'b1;
        dmem_rdata = 16'h6001;
        #1;
        check("sti ptr read", {15'd0, dmem_read}, 16'd1);
        next_cycle();
        dmem_resp  = 1'b0;
        dmem_rdata = 16'h0000;
        #1;
        check("sti write", {15'd0, dmem_write}, 16'd1);
        check("sti addr", dmem_address, 16'h6000);
        check("sti wdata", dmem_wdata, 16'h5555);
        check("sti be", {14'd0, dmem_byte_enable}, 16'd3);
        check("sti stall", {15'd0, stall}, 16'd1);
        #1;
        reset_n = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        check("sti rst req", {14'd0, dmem_read, dmem_write}, 16'd0);
        check("sti rst addr", dmem_address, 16'h0000);
        check("sti rst wdata", dmem_wdata, 16'h0000);
        check("sti rst be", {14'd0, dmem_byte_enable}, 16'd0);
        check("sti rst mem", mem_rdata, 16'h0000);
        check("sti rst stall", {15'd0, stall}, 16'd0);
        #2 reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            #1;
            check("sti post write", {15'd0, dmem_write}, 16'd0);
            check("sti post stall", {15'd0, stall}, 16'd0);
        end

`ifdef DCACHE_TIMEOUT_EN
        // LDR with no response: abort after four wait cycles
        next_cycle();
        drive(1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 16'h1000, 16'h0000);
        #1;
        check("to stall0", {15'd0, stall}, 16'd1);
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            #1;
            check("to read", {15'd0, dmem_read}, 16'd1);
            check("to stall", {15'd0, stall}, (c == 3) ? 16'd0 : 16'd1);
            check("to err_pre", {15'd0, mem_error}, 16'd0);
        end
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        check("to err", {15'd0, mem_error}, 16'd1);
        check("to read_off", {15'd0, dmem_read}, 16'd0);
        check("to stall_off", {15'd0, stall}, 16'd0);
        check("to mem", mem_rdata, 16'h0000);
        next_cycle();
        dmem_resp  = 1'b1;
        dmem_rdata = 16'h7777;
        #1;
        next_cycle();
        dmem_resp = 1'b0;
        #1;
        check("to sticky", {15'd0, mem_error}, 16'd1);
        check("to mem_hold", mem_rdata, 16'h0000);
        reset_n = 1'b0;
        #1;
        check("to err_rst", {15'd0, mem_error}, 16'd0);
        #2 reset_n = 1'b1;
`endif

        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
